// File: rtl/game_ctrl.sv
// game_ctrl: conditions the start/hit buttons and sequences IDLE/CLEAR/PLAY/OVER for the score counters.
// Define HIT_DEBOUNCE_EN to add a DB_CYCLES debounce filter on both synchronized buttons.
//
// state | meaning
// IDLE  | waiting for the first start press after reset
// CLEAR | one cycle: clear score, load time_left and prescaler
// PLAY  | game running, seconds countdown, hits accepted
// OVER  | time expired, waiting for start to play again

module game_ctrl #(
    parameter int CLK_PER_SEC  = 100000000,
    parameter int GAME_SECONDS = 30,
    parameter int DB_CYCLES    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_hit,
    output logic       gaming,
    output logic       score_zero,
    output logic       increase,
    output logic [5:0] time_left,
    output logic       game_over
);

    localparam int               PRE_W        = $clog2(CLK_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_MAX      = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [5:0]       SECONDS_INIT = 6'(GAME_SECONDS);

    typedef enum logic [1:0] {IDLE, CLEAR, PLAY, OVER} state_t;

    state_t           state;
    logic [PRE_W-1:0] prescale;
    logic             start_s1, start_s2, hit_s1, hit_s2;
    logic             start_lvl, hit_lvl;
    logic             start_prev, hit_prev;
    logic             start_pulse, hit_pulse;

    if (CLK_PER_SEC < 2 || GAME_SECONDS < 1 || GAME_SECONDS > 63 || DB_CYCLES < 1) begin : g_param_check
        $error("game_ctrl: parameter out of range");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            hit_s1   <= 1'b0;
            hit_s2   <= 1'b0;
        end else begin
            start_s1 <= btn_start;
            start_s2 <= start_s1;
            hit_s1   <= btn_hit;
            hit_s2   <= hit_s1;
        end
    end

`ifdef HIT_DEBOUNCE_EN
    localparam int              DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] start_cnt, hit_cnt;

    // Level follows the input only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_lvl <= 1'b0;
            hit_lvl   <= 1'b0;
            start_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            if (start_s2 == start_lvl) begin
                start_cnt <= '0;
            end else if (start_cnt == DB_MAX) begin
                start_lvl <= start_s2;
                start_cnt <= '0;
            end else begin
                start_cnt <= start_cnt + DB_W'(1);
            end
            if (hit_s2 == hit_lvl) begin
                hit_cnt <= '0;
            end else if (hit_cnt == DB_MAX) begin
                hit_lvl <= hit_s2;
                hit_cnt <= '0;
            end else begin
                hit_cnt <= hit_cnt + DB_W'(1);
            end
        end
    end
`else
    assign start_lvl = start_s2;
    assign hit_lvl   = hit_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev  <= 1'b0;
            hit_prev    <= 1'b0;
            start_pulse <= 1'b0;
            hit_pulse   <= 1'b0;
        end else begin
            start_prev  <= start_lvl;
            hit_prev    <= hit_lvl;
            start_pulse <= start_lvl & ~start_prev;
            hit_pulse   <= hit_lvl & ~hit_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prescale  <= '0;
            time_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pulse) state <= CLEAR;
                end
                CLEAR: begin
                    time_left <= SECONDS_INIT;
                    prescale  <= '0;
                    state     <= PLAY;
                end
                PLAY: begin
                    if (prescale == PRE_MAX) begin
                        prescale <= '0;
                        // Guarded at <=1 so time_left can never wrap below zero.
                        if (time_left <= 6'd1) begin
                            time_left <= '0;
                            state     <= OVER;
                        end else begin
                            time_left <= time_left - 6'd1;
                        end
                    end else begin
                        prescale <= prescale + PRE_W'(1);
                    end
                end
                OVER: begin
                    if (start_pulse) state <= CLEAR;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gaming     = (state == PLAY);
    assign score_zero = (state == CLEAR);
    assign game_over  = (state == OVER);
    assign increase   = hit_pulse & (state == PLAY);

endmodule
